inst_loader: RTL and testbench

INST_LOADER -- requirements
Module: inst_loader

---
 rtl/inst_loader.sv | 138 +++++++++++++
 tb/tb_inst_loader.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_loader.sv
// Instruction-memory loader: receives a length-prefixed little-endian byte stream,
// writes it into instruction memory word by word, then releases the core from reset.
module inst_loader #(
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [7:0]            s_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  core_rst_n,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

    localparam int unsigned CNT_W = ADDR_WIDTH + 1;
    localparam logic [32:0] DEPTH = 33'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        DONE,
        ERR
    } state_t;

    state_t             state;
    logic [1:0]         byte_cnt;
    logic [CNT_W-1:0]   word_cnt;
    logic [31:0]        len_reg;
    logic [23:0]        len_lo;
    logic [23:0]        shift_reg;

    logic               xfer_c;
    logic [31:0]        len_next_c;
    logic [31:0]        word_next_c;
    logic [CNT_W-1:0]   word_cnt_inc_c;

    // Incoming byte lands in the top lane; earlier bytes shift down toward bit 0.
    assign xfer_c         = s_valid & s_ready;
    assign len_next_c     = {s_data, len_lo};
    assign word_next_c    = {s_data, shift_reg};
    assign word_cnt_inc_c = word_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            byte_cnt   <= 2'd0;
            word_cnt   <= '0;
            len_reg    <= 32'd0;
            len_lo     <= 24'd0;
            shift_reg  <= 24'd0;
            s_ready    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            core_rst_n <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state      <= LEN;
                        byte_cnt   <= 2'd0;
                        word_cnt   <= '0;
                        s_ready    <= 1'b1;
                        core_rst_n <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                    end
                end
                LEN: begin
                    if (xfer_c) begin
                        len_lo   <= len_next_c[31:8];
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            len_reg <= len_next_c;
                            if (len_next_c == 32'd0) begin
                                state      <= DONE;
                                s_ready    <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                core_rst_n <= 1'b1;
                            end else if ({1'b0, len_next_c} > DEPTH) begin
                                state   <= ERR;
                                s_ready <= 1'b0;
                                busy    <= 1'b0;
                                err     <= 1'b1;
                            end else begin
                                state <= DATA;
                            end
                        end
                    end
                end
                DATA: begin
                    if (xfer_c) begin
                        shift_reg <= word_next_c[31:8];
                        byte_cnt  <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            state     <= WRITE;
                            s_ready   <= 1'b0;
                            mem_we    <= 1'b1;
                            mem_addr  <= word_cnt[ADDR_WIDTH-1:0];
                            mem_wdata <= word_next_c;
                        end
                    end
                end
                WRITE: begin
                    mem_we   <= 1'b0;
                    word_cnt <= word_cnt_inc_c;
                    // Counter is one bit wider than the address so a full-depth load terminates.
                    if (32'(word_cnt_inc_c) == len_reg) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        core_rst_n <= 1'b1;
                    end else begin
                        state   <= DATA;
                        s_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_loader.sv
// Randomized self-checking bench for inst_loader (ADDR_WIDTH=4, 16-word memory).
module tb_inst_loader;

    localparam int unsigned AW = 4;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          s_valid;
    logic          s_ready;
    logic [7:0]    s_data;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          core_rst_n;
    logic          busy;
    logic          done;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0]   words[$];
    logic [AW-1:0] wa[$];
    logic [31:0]   wd[$];

    inst_loader #(.ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_rst_n (core_rst_n),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    // Memory-write observer: one entry per cycle that mem_we is high.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: continuous valid, 1: random gaps, 2: valid toggles every other cycle
    task automatic send_byte(input logic [7:0] b, input int mode);
        int t = 0;
        int idle = (mode == 1) ? int'($urandom_range(0, 2)) : ((mode == 2) ? 1 : 0);
        s_valid = 1'b0;
        repeat (idle) @(negedge clk);
        s_valid = 1'b1;
        s_data  = b;
        while (!s_ready && t < 64) begin
            @(negedge clk);
            t++;
        end
        n_checks++;
        if (s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_byte_ready: s_ready=%b required 1 (byte %h)", s_ready, b);
        end
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    // Frame built from the word list: 4 LE length bytes, then each word LE.
    task automatic send_len(input int n, input int mode);
        for (int b = 0; b < 4; b++) send_byte(8'(n >> (8 * b)), mode);
    endtask

    task automatic send_words(input int mode);
        for (int w = 0; w < words.size(); w++)
            for (int b = 0; b < 4; b++) send_byte(8'(words[w] >> (8 * b)), mode);
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err, s_ready} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b addr=%h wdata=%h core_rst_n=%b busy=%b done=%b err=%b rdy=%b required all 0",
                     mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err, s_ready);
        end
        s_valid = 1'b1;
        s_data  = 8'h55;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        n_checks++;
        if (s_ready !== 1'b0 || busy !== 1'b0 || core_rst_n !== 1'b0 || wa.size() != 0) begin
            n_fail++;
            $display("FAIL idle_hold: s_ready=%b busy=%b core_rst_n=%b writes=%0d required 0 0 0 0",
                     s_ready, busy, core_rst_n, wa.size());
        end
    endtask

    task automatic test_basic();
        words = '{32'h0000_0013, 32'h0000_00B3};
        wa.delete(); wd.delete();
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1 || core_rst_n !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL start_to_len: busy=%b s_ready=%b core_rst_n=%b done=%b required 1 1 0 0",
                     busy, s_ready, core_rst_n, done);
        end
        send_len(2, 0);
        send_words(0);
        n_checks++;
        if (mem_we !== 1'b1 || mem_addr !== AW'(1) || mem_wdata !== 32'h0000_00B3) begin
            n_fail++;
            $display("FAIL write_latency: we=%b addr=%h data=%h required 1 1 000000b3", mem_we, mem_addr, mem_wdata);
        end
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== AW'(1)) begin
            n_fail++;
            $display("FAIL basic_done: done=%b core_rst_n=%b busy=%b we=%b addr=%h required 1 1 0 0 1",
                     done, core_rst_n, busy, mem_we, mem_addr);
        end
        n_checks++;
        if (wa.size() != 2) begin
            n_fail++;
            $display("FAIL basic_count: writes=%0d required 2", wa.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (wa[i] !== AW'(i) || wd[i] !== words[i]) begin
                    n_fail++;
                    $display("FAIL basic_write%0d: addr=%h data=%h required %h %h", i, wa[i], wd[i], AW'(i), words[i]);
                end
            end
        end
    endtask

    task automatic test_zero_len();
        wa.delete(); wd.delete();
        pulse_start();
        n_checks++;
        if (done !== 1'b0 || core_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL restart_clears: done=%b core_rst_n=%b required 0 0", done, core_rst_n);
        end
        send_len(0, 1);
        n_checks++;
        if (done !== 1'b1 || core_rst_n !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_len_done: done=%b core_rst_n=%b busy=%b s_ready=%b required 1 1 0 0",
                     done, core_rst_n, busy, s_ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (wa.size() != 0) begin
            n_fail++;
            $display("FAIL zero_len_writes: writes=%0d required 0", wa.size());
        end
    endtask

    task automatic test_overflow();
        wa.delete(); wd.delete();
        pulse_start();
        send_len(DEPTH + 1, 0);
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (3) @(negedge clk);
        s_valid = 1'b0;
        n_checks++;
        if (err !== 1'b1 || s_ready !== 1'b0 || core_rst_n !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || wa.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_err: err=%b s_ready=%b core_rst_n=%b busy=%b done=%b writes=%0d required 1 0 0 0 0 0",
                     err, s_ready, core_rst_n, busy, done, wa.size());
        end
        pulse_start();
        n_checks++;
        if (err !== 1'b0 || busy !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL overflow_restart: err=%b busy=%b s_ready=%b required 0 1 1", err, busy, s_ready);
        end
        send_len(0, 0);
    endtask

    task automatic test_stall();
        words = '{32'hDEAD_BEEF};
        wa.delete(); wd.delete();
        pulse_start();
        send_len(1, 2);
        send_words(2);
        repeat (4) @(negedge clk);
        n_checks++;
        if (wa.size() != 1 || wa[0] !== AW'(0) || wd[0] !== 32'hDEAD_BEEF || done !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_write: writes=%0d addr=%h data=%h done=%b required 1 0 deadbeef 1",
                     wa.size(), (wa.size() > 0) ? wa[0] : AW'(0), (wd.size() > 0) ? wd[0] : 32'h0, done);
        end
    endtask

    task automatic test_reset_mid();
        pulse_start();
        send_len(1, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_checks++;
        if ({mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err, s_ready} !== '0) begin
            n_fail++;
            $display("FAIL midword_reset: we=%b addr=%h wdata=%h core_rst_n=%b busy=%b done=%b err=%b rdy=%b required all 0",
                     mem_we, mem_addr, mem_wdata, core_rst_n, busy, done, err, s_ready);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (core_rst_n !== 1'b0) begin
            n_fail++;
            $display("FAIL core_held: core_rst_n=%b required 0", core_rst_n);
        end
        words = '{32'h1234_5678, 32'h9ABC_DEF0};
        wa.delete(); wd.delete();
        pulse_start();
        send_len(2, 1);
        send_words(1);
        @(negedge clk);
        n_checks++;
        if (wa.size() != 2 || wa[0] !== AW'(0) || wd[0] !== words[0] || wd[1] !== words[1] || done !== 1'b1) begin
            n_fail++;
            $display("FAIL reload_after_reset: writes=%0d addr0=%h data0=%h done=%b required 2 0 %h 1",
                     wa.size(), (wa.size() > 0) ? wa[0] : AW'(0), (wd.size() > 0) ? wd[0] : 32'h0, done, words[0]);
        end
    endtask

    task automatic test_start_ignored();
        words = '{32'hA1B2_C3D4, 32'h0F0E_0D0C, 32'h5566_7788};
        wa.delete(); wd.delete();
        pulse_start();
        send_len(3, 0);
        send_byte(8'hD4, 0);
        send_byte(8'hC3, 0);
        pulse_start();
        n_checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL start_while_busy: busy=%b s_ready=%b required 1 1", busy, s_ready);
        end
        send_byte(8'hB2, 0);
        send_byte(8'hA1, 0);
        for (int w = 1; w < 3; w++)
            for (int b = 0; b < 4; b++) send_byte(8'(words[w] >> (8 * b)), 0);
        @(negedge clk);
        n_checks++;
        if (wa.size() != 3 || done !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_start_count: writes=%0d done=%b required 3 1", wa.size(), done);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_checks++;
                if (wa[i] !== AW'(i) || wd[i] !== words[i]) begin
                    n_fail++;
                    $display("FAIL ignored_start_write%0d: addr=%h data=%h required %h %h", i, wa[i], wd[i], AW'(i), words[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int n = (k == 0) ? int'(DEPTH) : int'($urandom_range(1, DEPTH));
            words.delete();
            for (int i = 0; i < n; i++) words.push_back($urandom);
            wa.delete(); wd.delete();
            pulse_start();
            send_len(n, 1);
            send_words(1);
            @(negedge clk);
            n_checks++;
            if (done !== 1'b1 || core_rst_n !== 1'b1 || wa.size() != n) begin
                n_fail++;
                $display("FAIL rand%0d_done: done=%b core_rst_n=%b writes=%0d required 1 1 %0d",
                         k, done, core_rst_n, wa.size(), n);
            end else begin
                for (int i = 0; i < n; i++) begin
                    n_checks++;
                    if (wa[i] !== AW'(i) || wd[i] !== words[i]) begin
                        n_fail++;
                        $display("FAIL rand%0d_write%0d: addr=%h data=%h required %h %h", k, i, wa[i], wd[i], AW'(i), words[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        s_valid = 1'b0;
        s_data  = 8'h00;
        @(negedge clk);
        test_reset();
        test_basic();
        test_zero_len();
        test_overflow();
        test_stall();
        test_reset_mid();
        test_start_ignored();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
